// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a read-only fetch port and a
// read/write data port, with a forced release when the memory never acknowledges.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  imem_req_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output logic [DATA_WIDTH-1:0] imem_rdata_o,
    output logic                  imem_ack_o,
    input  logic                  dmem_req_i,
    input  logic                  dmem_we_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_ack_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic                  busy_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2} state_e;

    // A disabled timeout still needs a legal (1-bit) counter.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e                state_q, state_d;
    logic                  last_d_q, last_d_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic to_hit;
    logic txn_done;
    logic pick_d;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        to_hit = 1'b0;
        if (TIMEOUT != 0 && state_q != IDLE && !mem_ack_i && int'(cnt_q) == TIMEOUT - 1)
            to_hit = 1'b1;
        txn_done = (state_q != IDLE) && (mem_ack_i || to_hit);
    end

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pick_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (imem_req_i || dmem_req_i) begin
                    // On contention the port that was not served last wins.
                    pick_d    = dmem_req_i && (!imem_req_i || !last_d_q);
                    state_d   = pick_d ? GRANT_D : GRANT_I;
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    if (pick_d) begin
                        mem_we_d    = dmem_we_i;
                        mem_addr_d  = dmem_addr_i;
                        mem_wdata_d = dmem_wdata_i;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = imem_addr_i;
                        mem_wdata_d = '0;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                if (txn_done) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    last_d_d  = (state_q == GRANT_D);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        imem_ack_o   = (state_q == GRANT_I) && txn_done;
        dmem_ack_o   = (state_q == GRANT_D) && txn_done;
        imem_rdata_o = (imem_ack_o && mem_ack_i) ? mem_rdata_i : '0;
        dmem_rdata_o = (dmem_ack_o && mem_ack_i) ? mem_rdata_i : '0;
        busy_o       = (state_q != IDLE);
        timeout_o    = to_hit;
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized two-port traffic checked against a transaction-level
// model of the arbiter and a shadow memory.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          arst_ni = 1'b0;
    logic          imem_req_i = 1'b0;
    logic [AW-1:0] imem_addr_i = '0;
    logic [DW-1:0] imem_rdata_o;
    logic          imem_ack_o;
    logic          dmem_req_i = 1'b0;
    logic          dmem_we_i = 1'b0;
    logic [AW-1:0] dmem_addr_i = '0;
    logic [DW-1:0] dmem_wdata_i = '0;
    logic [DW-1:0] dmem_rdata_o;
    logic          dmem_ack_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          mem_ack_i = 1'b0;
    logic          busy_o;
    logic          timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i),
        .imem_rdata_o(imem_rdata_o), .imem_ack_o(imem_ack_o),
        .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_addr_i(dmem_addr_i),
        .dmem_wdata_i(dmem_wdata_i), .dmem_rdata_o(dmem_rdata_o), .dmem_ack_o(dmem_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs;
        imem_req_i   = 1'b0;
        imem_addr_i  = '0;
        dmem_req_i   = 1'b0;
        dmem_we_i    = 1'b0;
        dmem_addr_i  = '0;
        dmem_wdata_i = '0;
        mem_ack_i    = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic do_reset;
        arst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1 arst_ni = 1'b1;
    endtask

    task automatic test_reset;
        arst_ni = 1'b0;
        idle_inputs();
        imem_req_i  = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if ({mem_req_o, mem_we_o, imem_ack_o, dmem_ack_o, busy_o, timeout_o} !== 6'b0 ||
            mem_addr_o !== '0 || mem_wdata_o !== '0 || imem_rdata_o !== '0 || dmem_rdata_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b we=%b iack=%b dack=%b busy=%b to=%b addr=%h wdata=%h ir=%h dr=%h, required all 0",
                     mem_req_o, mem_we_o, imem_ack_o, dmem_ack_o, busy_o, timeout_o,
                     mem_addr_o, mem_wdata_o, imem_rdata_o, dmem_rdata_o);
        end
        idle_inputs();
        @(posedge clk_i);
        #1 arst_ni = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if ({mem_req_o, busy_o, imem_ack_o, dmem_ack_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got req=%b busy=%b iack=%b dack=%b, required 0",
                     mem_req_o, busy_o, imem_ack_o, dmem_ack_o);
        end
    endtask

    task automatic test_imem_only;
        tick();
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h0000_1000;
        mem_ack_i   = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({mem_req_o, busy_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL imem_pre_grant: got req=%b busy=%b, required 00", mem_req_o, busy_o);
        end
        tick();
        mem_ack_i   = mem_req_o;
        mem_rdata_i = 32'hCAFE_0001;
        @(negedge clk_i);
        n_checks++;
        if ({mem_req_o, mem_we_o, busy_o, imem_ack_o, dmem_ack_o, timeout_o} !== 6'b101100 ||
            mem_addr_o !== 32'h0000_1000 || mem_wdata_o !== '0) begin
            n_fail++;
            $display("FAIL imem_grant: got req=%b we=%b busy=%b iack=%b dack=%b to=%b addr=%h wdata=%h, required 101100 addr=00001000 wdata=0",
                     mem_req_o, mem_we_o, busy_o, imem_ack_o, dmem_ack_o, timeout_o, mem_addr_o, mem_wdata_o);
        end
        n_checks++;
        if (imem_rdata_o !== 32'hCAFE_0001 || dmem_rdata_o !== '0) begin
            n_fail++;
            $display("FAIL imem_rdata: got i=%h d=%h, required i=cafe0001 d=0", imem_rdata_o, dmem_rdata_o);
        end
        tick();
        imem_req_i = 1'b0;
        mem_ack_i  = mem_req_o;
        @(negedge clk_i);
        n_checks++;
        if ({mem_req_o, busy_o, imem_ack_o} !== 3'b000 || imem_rdata_o !== '0) begin
            n_fail++;
            $display("FAIL imem_release: got req=%b busy=%b iack=%b ir=%h, required 0",
                     mem_req_o, busy_o, imem_ack_o, imem_rdata_o);
        end
    endtask

    task automatic test_dmem_write;
        tick();
        mem_ack_i    = 1'b0;
        mem_rdata_i  = '0;
        dmem_req_i   = 1'b1;
        dmem_we_i    = 1'b1;
        dmem_addr_i  = 32'h0000_2000;
        dmem_wdata_i = 32'hDEAD_BEEF;
        tick();
        mem_ack_i = mem_req_o;
        @(negedge clk_i);
        n_checks++;
        if ({mem_req_o, mem_we_o, dmem_ack_o, imem_ack_o} !== 4'b1110 ||
            mem_addr_o !== 32'h0000_2000 || mem_wdata_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL dmem_write: got req=%b we=%b dack=%b iack=%b addr=%h wdata=%h, required 1110 addr=00002000 wdata=deadbeef",
                     mem_req_o, mem_we_o, dmem_ack_o, imem_ack_o, mem_addr_o, mem_wdata_o);
        end
        tick();
        idle_inputs();
        @(negedge clk_i);
        n_checks++;
        if ({mem_req_o, busy_o, dmem_ack_o, imem_ack_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL dmem_release: got req=%b busy=%b dack=%b iack=%b, required 0000",
                     mem_req_o, busy_o, dmem_ack_o, imem_ack_o);
        end
    endtask

    task automatic test_contention;
        logic [2:0] exp_tab [6];
        exp_tab = '{3'b000, 3'b101, 3'b000, 3'b110, 3'b000, 3'b101};  // {req, iack, dack}
        do_reset();
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) begin
                imem_req_i  = 1'b1;
                imem_addr_i = 32'h0000_0100;
                dmem_req_i  = 1'b1;
                dmem_we_i   = 1'b0;
                dmem_addr_i = 32'h0000_0200;
            end
            mem_ack_i   = mem_req_o;
            mem_rdata_i = 32'h5000_0000 + 32'(c);
            @(negedge clk_i);
            n_checks++;
            if ({mem_req_o, imem_ack_o, dmem_ack_o} !== exp_tab[c]) begin
                n_fail++;
                $display("FAIL contention_cycle%0d: got {req,iack,dack}=%b, required %b",
                         c, {mem_req_o, imem_ack_o, dmem_ack_o}, exp_tab[c]);
            end
            if (exp_tab[c][2]) begin
                n_checks++;
                if (mem_addr_o !== (exp_tab[c][1] ? 32'h0000_0100 : 32'h0000_0200)) begin
                    n_fail++;
                    $display("FAIL contention_addr%0d: got %h", c, mem_addr_o);
                end
            end
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_timeout;
        do_reset();
        tick();
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h0000_0040;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hBAD0_BAD0;
        for (int g = 1; g <= TO; g++) begin
            tick();
            @(negedge clk_i);
            n_checks++;
            if ({busy_o, mem_req_o, imem_ack_o, timeout_o} !== ((g < TO) ? 4'b1100 : 4'b1111)) begin
                n_fail++;
                $display("FAIL timeout_cycle%0d: got {busy,req,iack,to}=%b, required %b",
                         g, {busy_o, mem_req_o, imem_ack_o, timeout_o}, (g < TO) ? 4'b1100 : 4'b1111);
            end
        end
        n_checks++;
        if (imem_rdata_o !== '0) begin
            n_fail++;
            $display("FAIL timeout_rdata: got %h, required 0", imem_rdata_o);
        end
        tick();
        imem_req_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, mem_req_o, timeout_o, imem_ack_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_to_idle: got {busy,req,to,iack}=%b, required 0000",
                     {busy_o, mem_req_o, timeout_o, imem_ack_o});
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        tick();
        dmem_req_i   = 1'b1;
        dmem_we_i    = 1'b1;
        dmem_addr_i  = 32'h0000_0300;
        dmem_wdata_i = 32'h1234_5678;
        tick();
        tick();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        #1 arst_ni = 1'b0;
        #1;
        n_checks++;
        if ({mem_req_o, mem_we_o, imem_ack_o, dmem_ack_o, busy_o, timeout_o} !== 6'b0 ||
            mem_addr_o !== '0 || mem_wdata_o !== '0 || dmem_rdata_o !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got req=%b we=%b iack=%b dack=%b busy=%b to=%b addr=%h wdata=%h dr=%h, required all 0",
                     mem_req_o, mem_we_o, imem_ack_o, dmem_ack_o, busy_o, timeout_o, mem_addr_o, mem_wdata_o, dmem_rdata_o);
        end
        tick();
        arst_ni      = 1'b1;
        mem_ack_i    = 1'b0;
        imem_req_i   = 1'b1;
        imem_addr_i  = 32'h0000_0500;
        dmem_we_i    = 1'b0;
        dmem_addr_i  = 32'h0000_0600;
        tick();
        @(negedge clk_i);
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0600 || mem_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_first_grant: got req=%b addr=%h we=%b, required req=1 addr=00000600 we=0",
                     mem_req_o, mem_addr_o, mem_we_o);
        end
        do_reset();
    endtask

    task automatic test_random;
        logic [DW-1:0] mem [16];
        logic [DW-1:0] shadow [16];
        bit            m_idle   = 1'b1;   // model: current cycle is an arbitration cycle
        bit            m_first  = 1'b0;   // model: current cycle is the first grant cycle
        bit            m_last_d = 1'b0;   // model: dmem was the last port served
        bit            m_cur_d  = 1'b0;   // model: port holding the grant
        bit            resp_on  = 1'b0;
        int            wait_left = 0;
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [DW-1:0] e_wdata;
        logic          e_iack, e_dack;
        for (int k = 0; k < 16; k++) begin
            mem[k]    = $urandom;
            shadow[k] = mem[k];
        end
        do_reset();
        for (int cyc = 0; cyc < 700; cyc++) begin
            tick();
            if (mem_req_o && !resp_on) begin
                resp_on   = 1'b1;
                wait_left = $urandom_range(0, 3);
            end
            mem_ack_i   = resp_on && (wait_left == 0);
            mem_rdata_i = (mem_ack_i && !mem_we_o) ? mem[mem_addr_o[5:2]] : $urandom;
            if (!imem_req_i && $urandom_range(0, 2) == 0) begin
                imem_req_i  = 1'b1;
                imem_addr_i = AW'($urandom_range(0, 15)) << 2;
            end
            if (!dmem_req_i && $urandom_range(0, 2) == 0) begin
                dmem_req_i   = 1'b1;
                dmem_we_i    = 1'($urandom_range(0, 1));
                dmem_addr_i  = AW'($urandom_range(0, 15)) << 2;
                dmem_wdata_i = $urandom;
            end
            @(negedge clk_i);
            if (resp_on) begin
                if (mem_ack_i) begin
                    resp_on = 1'b0;
                    if (mem_we_o) mem[mem_addr_o[5:2]] = mem_wdata_o;
                end else begin
                    wait_left--;
                end
            end
            if (m_idle) begin
                n_checks++;
                if ({busy_o, mem_req_o, imem_ack_o, dmem_ack_o, timeout_o} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL rnd_idle c%0d: got {busy,req,iack,dack,to}=%b, required 0",
                             cyc, {busy_o, mem_req_o, imem_ack_o, dmem_ack_o, timeout_o});
                end
                if (imem_req_i || dmem_req_i) begin
                    m_cur_d = dmem_req_i && (!imem_req_i || !m_last_d);
                    e_addr  = m_cur_d ? dmem_addr_i : imem_addr_i;
                    e_we    = m_cur_d ? dmem_we_i : 1'b0;
                    e_wdata = m_cur_d ? dmem_wdata_i : '0;
                    m_idle  = 1'b0;
                    m_first = 1'b1;
                end
            end else begin
                if (m_first) begin
                    n_checks++;
                    if (mem_addr_o !== e_addr || mem_we_o !== e_we || mem_wdata_o !== e_wdata) begin
                        n_fail++;
                        $display("FAIL rnd_grant c%0d: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                                 cyc, mem_addr_o, mem_we_o, mem_wdata_o, e_addr, e_we, e_wdata);
                    end
                    m_first = 1'b0;
                end
                e_iack = mem_ack_i && !m_cur_d;
                e_dack = mem_ack_i && m_cur_d;
                n_checks++;
                if ({busy_o, mem_req_o, imem_ack_o, dmem_ack_o, timeout_o} !== {2'b11, e_iack, e_dack, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rnd_busy c%0d: got {busy,req,iack,dack,to}=%b, required %b",
                             cyc, {busy_o, mem_req_o, imem_ack_o, dmem_ack_o, timeout_o},
                             {2'b11, e_iack, e_dack, 1'b0});
                end
                if (mem_ack_i) begin
                    if (!m_cur_d) begin
                        n_checks++;
                        if (imem_rdata_o !== shadow[imem_addr_i[5:2]] || dmem_rdata_o !== '0) begin
                            n_fail++;
                            $display("FAIL rnd_imem_rdata c%0d: got i=%h d=%h, required i=%h d=0",
                                     cyc, imem_rdata_o, dmem_rdata_o, shadow[imem_addr_i[5:2]]);
                        end
                        imem_req_i = 1'b0;
                    end else begin
                        if (dmem_we_i) begin
                            shadow[dmem_addr_i[5:2]] = dmem_wdata_i;
                        end else begin
                            n_checks++;
                            if (dmem_rdata_o !== shadow[dmem_addr_i[5:2]] || imem_rdata_o !== '0) begin
                                n_fail++;
                                $display("FAIL rnd_dmem_rdata c%0d: got d=%h i=%h, required d=%h i=0",
                                         cyc, dmem_rdata_o, imem_rdata_o, shadow[dmem_addr_i[5:2]]);
                            end
                        end
                        dmem_req_i = 1'b0;
                    end
                    m_last_d = m_cur_d;
                    m_idle   = 1'b1;
                end
            end
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_imem_only();
        test_dmem_write();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
